// File: rtl/cp0_timer.sv
// cp0_timer -- CP0 Count/Compare timer (Reg 9 Count, Reg 11 Compare).
//
// Count advances once every PRESCALE enabled cycles. A sticky timer_pending
// flag is raised when an increment makes Count equal to Compare. The flag is
// cleared only by a Compare write or by reset.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   count_en       1 = prescaler and Count run; 0 = both frozen
//   cp0_we         MTC0 write strobe, one cycle per write
//   cp0_waddr[4:0] CP0 register number (9 = Count, 11 = Compare)
//   cp0_wdata[31:0] write data
//   count[31:0]    current Count
//   compare[31:0]  current Compare
//   timer_pending  sticky interrupt request (feeds IP[3] / Cause.TI)
module cp0_timer #(
  parameter int PRESCALE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_en,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // With PRESCALE=1, PRE_MAX is 0. pre never leaves 0, so tick reduces to count_en.
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic          tick;
  logic          count_wr;
  logic          compare_wr;
  logic [31:0]   count_inc;

  assign count_wr   = cp0_we && (cp0_waddr == 5'd9);
  assign compare_wr = cp0_we && (cp0_waddr == 5'd11);
  assign tick       = count_en && (pre == PRE_MAX);
  assign count_inc  = count + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      compare       <= '0;
      timer_pending <= 1'b0;
      pre           <= '0;
    end else begin
      // A Count write replaces any tick that would occur on the same edge and
      // restarts the prescale period.
      if (count_wr) begin
        count <= cp0_wdata;
        pre   <= '0;
      end else if (count_en) begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick) count <= count_inc;
      end

      // A Compare write acknowledges the interrupt. The clear takes priority
      // over a match against the old Compare on the same edge.
      if (compare_wr) begin
        compare       <= cp0_wdata;
        timer_pending <= 1'b0;
      end else if (!count_wr && tick && (count_inc == compare)) begin
        timer_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp0_timer.sv
module tb_cp0_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        count_en = 1'b0;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_waddr = '0;
  logic [31:0] cp0_wdata = '0;

  logic [31:0] count_a, compare_a, count_b, compare_b;
  logic        pend_a, pend_b;

  always #5 clk = ~clk;

  // Instance a: PRESCALE=2. Instance b: PRESCALE=1. Both share the stimulus.
  cp0_timer #(.PRESCALE(2)) dut_a (
    .clk(clk), .reset(reset), .count_en(count_en), .cp0_we(cp0_we),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .count(count_a), .compare(compare_a), .timer_pending(pend_a));

  cp0_timer #(.PRESCALE(1)) dut_b (
    .clk(clk), .reset(reset), .count_en(count_en), .cp0_we(cp0_we),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .count(count_b), .compare(compare_b), .timer_pending(pend_b));

  typedef struct {
    logic        rst;
    logic        en;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] ec;
    logic [31:0] ecmp;
    logic        ep;
    logic        sel;   // 0 = check dut_a, 1 = check dut_b
  } vec_t;

  vec_t  tbl[$];
  vec_t  sb[$];
  string sb_name[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic void add(input logic rst, input logic en, input logic we,
                              input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] ec, input logic [31:0] ecmp,
                              input logic ep);
    vec_t v;
    v.rst = rst; v.en = en; v.we = we; v.addr = a; v.data = d;
    v.ec = ec; v.ecmp = ecmp; v.ep = ep; v.sel = 1'b0;
    tbl.push_back(v);
  endfunction

  // Drive one edge worth of inputs, queue the expected post-edge state, then
  // pop it and compare once the DUT has updated.
  task automatic drv(input string name, input logic sel, input logic rst,
                     input logic en, input logic we, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] ec,
                     input logic [31:0] ecmp, input logic ep);
    vec_t v, e;
    string nm;
    logic [31:0] c, cm;
    logic p;
    v.rst = rst; v.en = en; v.we = we; v.addr = a; v.data = d;
    v.ec = ec; v.ecmp = ecmp; v.ep = ep; v.sel = sel;
    @(negedge clk);
    reset = rst; count_en = en; cp0_we = we; cp0_waddr = a; cp0_wdata = d;
    sb.push_back(v);
    sb_name.push_back(name);
    @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e  = sb.pop_front();
      nm = sb_name.pop_front();
      c  = e.sel ? count_b   : count_a;
      cm = e.sel ? compare_b : compare_a;
      p  = e.sel ? pend_b    : pend_a;
      if (c !== e.ec || cm !== e.ecmp || p !== e.ep) begin
        n_bad++;
        $display("FAIL %s: got count=%h compare=%h pend=%b, want count=%h compare=%h pend=%b",
                 nm, c, cm, p, e.ec, e.ecmp, e.ep);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---- Table: reset/run, match/acknowledge, wrap (PRESCALE=2) ----
    add(1,0,0,0,0,            0,0,0);
    add(1,1,0,0,0,            0,0,0);
    add(0,1,0,0,0,            0,0,0);
    add(0,1,0,0,0,            1,0,0);   // first increment 2 cycles after release
    add(0,1,0,0,0,            1,0,0);
    add(0,1,0,0,0,            2,0,0);
    add(0,1,0,0,0,            2,0,0);
    add(0,1,0,0,0,            3,0,0);
    add(0,1,0,0,0,            3,0,0);
    add(0,1,0,0,0,            4,0,0);
    add(0,1,0,0,0,            4,0,0);
    add(0,1,0,0,0,            5,0,0);   // 10 cycles after release
    add(0,1,1,9,1,            1,0,0);   // Count=1
    add(0,1,1,11,3,           1,3,0);   // Compare=3
    add(0,1,0,0,0,            2,3,0);
    add(0,1,0,0,0,            2,3,0);
    add(0,1,0,0,0,            3,3,1);   // pending rises with count==3
    add(0,1,0,0,0,            3,3,1);
    add(0,1,0,0,0,            4,3,1);
    add(0,1,0,0,0,            4,3,1);
    add(0,1,0,0,0,            5,3,1);   // sticky
    add(0,1,1,11,32'h100,     5,32'h100,0);  // acknowledge
    add(0,1,0,0,0,            6,32'h100,0);
    add(0,1,1,9,32'hFFFF_FFFE, 32'hFFFF_FFFE,32'h100,0);
    add(0,1,1,11,0,           32'hFFFF_FFFE,0,0);
    add(0,1,0,0,0,            32'hFFFF_FFFF,0,0);
    add(0,1,0,0,0,            32'hFFFF_FFFF,0,0);
    add(0,1,0,0,0,            0,0,1);   // wrap match
    add(0,1,0,0,0,            0,0,1);
    for (int i = 0; i < tbl.size(); i++)
      drv($sformatf("tbl[%0d]", i), 1'b0, tbl[i].rst, tbl[i].en, tbl[i].we,
          tbl[i].addr, tbl[i].data, tbl[i].ec, tbl[i].ecmp, tbl[i].ep);

    // ---- Collisions ----
    drv("coll_cnt_wr",  0, 0,1,1,9,32'h20,   32'h20,0,1);      // count write keeps pending
    drv("coll_cmp_wr",  0, 0,1,1,11,32'h21,  32'h20,32'h21,0);
    drv("coll_cnt_tick",0, 0,1,1,9,32'h10,   32'h10,32'h21,0); // tick+match overridden
    drv("coll_cnt_p1",  0, 0,1,0,0,0,        32'h10,32'h21,0);
    drv("coll_cnt_p2",  0, 0,1,0,0,0,        32'h11,32'h21,0); // 2 cycles later
    drv("coll_cmp_set", 0, 0,1,1,11,32'h12,  32'h11,32'h12,0);
    drv("coll_cmp_tick",0, 0,1,1,11,32'h40,  32'h12,32'h40,0); // clear wins, count incr

    // ---- Freeze ----
    drv("frz_pre1",     0, 0,1,0,0,0,        32'h12,32'h40,0); // pre=1
    for (int i = 0; i < 3; i++)
      drv($sformatf("frz_a%0d", i), 0, 0,0,0,0,0, 32'h12,32'h40,0);
    drv("frz_resume",   0, 0,1,0,0,0,        32'h13,32'h40,0); // held pre ticks at once
    drv("frz_pre1b",    0, 0,1,0,0,0,        32'h13,32'h40,0);
    drv("frz_b0",       0, 0,0,0,0,0,        32'h13,32'h40,0);
    drv("frz_b1",       0, 0,0,0,0,0,        32'h13,32'h40,0);
    drv("frz_wr",       0, 0,0,1,9,32'hABCD, 32'hABCD,32'h40,0);
    for (int i = 0; i < 4; i++)
      drv($sformatf("frz_b%0d", i+3), 0, 0,0,0,0,0, 32'hABCD,32'h40,0);
    drv("frz_run1",     0, 0,1,0,0,0,        32'hABCD,32'h40,0);
    drv("frz_run2",     0, 0,1,0,0,0,        32'hABCE,32'h40,0);

    // ---- PRESCALE=1 (dut_b) ----
    drv("p1_rst",       1, 1,0,0,0,0,        0,0,0);
    drv("p1_run1",      1, 0,1,0,0,0,        1,0,0);
    drv("p1_run2",      1, 0,1,0,0,0,        2,0,0);
    drv("p1_cmp",       1, 0,1,1,11,4,       3,4,0);
    drv("p1_match",     1, 0,1,0,0,0,        4,4,1);
    drv("p1_addr12",    1, 0,1,1,12,0,       5,4,1);
    drv("p1_addr12_frz",1, 0,0,1,12,32'hFFFF,5,4,1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_timer.md
# cp0_timer

Count/Compare timer for coprocessor 0 (CP0 Reg 9 Count, CP0 Reg 11 Compare). It advances a free-running 32-bit Count through a prescaler and raises a sticky `timer_pending` flag when Count reaches Compare. `timer_pending` drives IP[3] and the TI bit of the Cause register directly. Software writes Count and Compare through the CP0 write port (MTC0); a Compare write acknowledges the interrupt.

## Interface

Parameters:
- `PRESCALE`, default 2: cycles per Count increment; legal range 1..256.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `count_en`  in  1  1 = timer runs; 0 = prescaler and Count frozen (debug/halt).
- `cp0_we`  in  1  CP0 write strobe (MTC0), one cycle per write.
- `cp0_waddr`  in  5  CP0 register number; only 9 and 11 are decoded.
- `cp0_wdata`  in  32  write data.
- `count`  out  32  current Count register.
- `compare`  out  32  current Compare register.
- `timer_pending`  out  1  sticky timer interrupt request.

## Operation

- Registers: `count`, `compare`, `timer_pending`, and an internal prescaler `pre` (width clog2(PRESCALE), minimum 1 bit).
- Reset: `count`=0, `compare`=0, `timer_pending`=0, `pre`=0. All outputs are registered.
- Tick: `tick` = `count_en` && (`pre` == PRESCALE-1).
  - When `count_en`=1: `pre` <= tick ? 0 : `pre`+1.
  - When `count_en`=0: `pre` holds.
  - If PRESCALE=1, `tick` = `count_en`.
- Increment: on tick, `count` <= `count`+1, modulo 2^32. 0xFFFFFFFF wraps to 0x00000000 with no flag.
- Match: on tick, if (`count`+1) == `compare` (old values), `timer_pending` <= 1. This includes the wrap case, where `compare`=0 and `count`=0xFFFFFFFF.
- Pending is sticky. It stays 1 until a Compare write or reset. Further matches have no additional effect.
- Count write (`cp0_we` && `cp0_waddr`==9):
  - `count` <= `cp0_wdata` and `pre` <= 0.
  - Overrides a same-cycle tick: no increment, no match evaluation.
  - Writing a value equal to `compare` does NOT set pending.
- Compare write (`cp0_we` && `cp0_waddr`==11):
  - `compare` <= `cp0_wdata` and `timer_pending` <= 0.
  - Clear wins over a same-cycle match against the old `compare`.
  - Count increments normally in that cycle.
- Writes to any other address: no effect on this block.
- Priority per edge, highest first: reset > Count write > Compare-write clear > tick/match.
- `count_en`=0 blocks ticks only; Count and Compare writes still apply.

## Timing

- Write latency: one edge. `count`/`compare` show the written value in the cycle after the `cp0_we` cycle.
- Increment period: with `count_en` held 1 and no writes, `count` increments every PRESCALE cycles. The first increment after reset or a Count write happens PRESCALE cycles later.
- Pending latency: `timer_pending` rises on the same edge where `count` becomes equal to `compare`. The Cause register captures it one edge later.
- Clear latency: `timer_pending` falls on the edge that writes Compare.
- Reset mid-count: the next edge after `reset`=1 returns all state to reset values regardless of `cp0_we` or `count_en`.
- No handshake. Every `cp0_we` cycle is accepted unconditionally.

## Test plan

All scenarios use PRESCALE=2 unless noted.

1. **Reset and run.** Assert reset, then release with `count_en`=1 and no writes.
   - `count`=0 at release.
   - `count`=1 two cycles later, `count`=5 ten cycles later.
   - `timer_pending` stays 0.
2. **Match and acknowledge.**
   - Write Compare=3 and hold `count_en`=1 → `timer_pending` rises on the edge where `count` becomes 3 and stays 1 as `count` passes 4, 5.
   - Write Compare=0x100 → `timer_pending`=0 the next cycle.
3. **Wrap.** Write Count=0xFFFFFFFE and Compare=0.
   - `count` reads 0xFFFFFFFF, then 0x00000000.
   - `timer_pending` rises on the edge where `count` becomes 0.
4. **Collisions.**
   - Count write of 0x10 on a tick edge with `compare`=`count`+1 → `count`=0x10, `timer_pending`=0, next increment 2 cycles later.
   - Compare write on a matching tick edge → `timer_pending`=0 and `count` incremented.
5. **Freeze.** Drop `count_en` for 7 cycles mid-run.
   - `count` and `pre` hold.
   - A Count write of 0xABCD during the freeze is visible on the next cycle.
   - Counting resumes from 0xABCD and takes 2 cycles to reach 0xABCE.
6. **PRESCALE=1.** `count` increments every cycle with `count_en`=1.
   - Compare=`count`+1 sets pending on the very next edge.
   - Writes to address 12 change nothing.
